data_sram_responder: RTL

- Responder end of the CPU's synchronous SRAM interface (en / we[3:0] / addr / wdata → rdata).
- Models an on-chip word-addressed RAM with byte-lane writes and one-cycle read latency.
- Self-clears its contents after reset, flags out-of-range accesses, and sits between the CPU top and the testbench or SoC memory map.

---
 rtl/sram_resp_pkg.sv | 22 ++
 rtl/sram_resp_mem.sv | 43 ++++
 rtl/data_sram_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and helpers for the data SRAM responder.
//   state_e        : responder FSM states (CLEAR while self-clearing, READY after)
//   LANES, WORD_W  : byte lanes per word and word width
//   addr_in_range  : true when a byte offset from the base falls inside the RAM
package sram_resp_pkg;

  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // The offset is in range when no bit at or above (addr_w+2) is set,
  // i.e. off < 4 * 2**addr_w. Shifting avoids overflowing 4*2**addr_w.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] off,
                                         input int unsigned addr_w);
    return (off >> (addr_w + 2)) == '0;
  endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Word-addressed RAM, 2**ADDR_W x 32, with per-lane write enables and a
// registered read-first output.
//   clk, resetn : clock, synchronous active-low reset (resets rdata only)
//   we, be      : write strobe and byte-lane enables
//   addr, wdata : word index and write data (lane i = bits [8i+7:8i])
//   rd_en       : load rdata with mem[addr] (old contents on a write)
//   rd_zero     : load rdata with 0 (takes priority over rd_en)
//   rdata       : registered read data; holds when neither rd_en nor rd_zero
module sram_resp_mem
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_zero,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Contents are not reset; the owner clears them word by word after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  // Non-blocking read of mem alongside the write gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!resetn)      rdata <= '0;
    else if (rd_zero) rdata <= '0;
    else if (rd_en)   rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU synchronous SRAM interface. After reset it clears
// every word (CLEAR), then serves byte-lane writes and 1-cycle reads (READY).
// Accesses outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W) are dropped, return 0
// and set a sticky oor_err.
// Optional build macro SRAM_RESP_STATS_EN: saturating in-range read/write
// counters on rd_cnt/wr_cnt; without it both ports are tied to 0.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   sram_en, sram_we       : request strobe, byte-lane write enables (0 = read)
//   sram_addr, sram_wdata  : byte address, write data
//   sram_rdata             : read data, valid the cycle after the request
//   init_done              : high once the post-reset clear has finished
//   oor_err                : sticky out-of-range flag
//   rd_cnt, wr_cnt         : access counters (optional feature)
module data_sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sram_en,
  input  logic [LANES-1:0]  sram_we,
  input  logic [31:0]       sram_addr,
  input  logic [WORD_W-1:0] sram_wdata,
  output logic [WORD_W-1:0] sram_rdata,
  output logic              init_done,
  output logic              oor_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == '1) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign init_done = (state_q == READY);

  // Address decode (32-bit wrapping subtract, so addresses below the base
  // land far out of range).
  logic [31:0]       off;
  logic              in_rng;
  logic [ADDR_W-1:0] idx;
  assign off    = sram_addr - BASE_ADDR;
  assign in_rng = addr_in_range(off, ADDR_W);
  assign idx    = off[ADDR_W+1:2];

  logic clearing, cpu_acc, cpu_rd, cpu_wr, cpu_oor;
  assign clearing = (state_q == CLEAR);
  assign cpu_acc  = init_done && sram_en;
  assign cpu_rd   = cpu_acc && in_rng && (sram_we == '0);
  assign cpu_wr   = cpu_acc && in_rng && (sram_we != '0);
  assign cpu_oor  = cpu_acc && !in_rng;

  // The clear and CPU traffic never overlap, so they share the one port.
  sram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .we      (clearing || cpu_wr),
    .be      (clearing ? {LANES{1'b1}} : sram_we),
    .addr    (clearing ? clr_ptr_q : idx),
    .wdata   (clearing ? '0 : sram_wdata),
    .rd_en   (cpu_acc && in_rng),
    .rd_zero (clearing || cpu_oor),
    .rdata   (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn)      oor_err <= 1'b0;
    else if (cpu_oor) oor_err <= 1'b1;
  end

`ifdef SRAM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (cpu_rd && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (cpu_wr && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
